// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the parametrised synchronous FIFO.
// Provides the occupancy-counter width, the wrap-aware pointer increment
// and the read-mode selector constants used by sync_fifo_param.
package fifo_pkg;

   // Read-mode selector values for the FWFT parameter
   localparam int MODE_STD  = 0;
   localparam int MODE_FWFT = 1;

   // Bits needed to hold an occupancy of 0..depth inclusive
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Advance a pointer, wrapping explicitly from depth-1 to 0 so that
   // non-power-of-two depths never alias onto unused storage slots
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH register array for sync_fifo_param.
// One synchronous write port, one asynchronous read port. The array is
// deliberately not reset; the FIFO control logic tracks which entries are live.
module fifo_mem #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Store the incoming word at the write address on an accepted write
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO of arbitrary depth with occupancy count,
// programmable almost-full/almost-empty thresholds and a standard or
// first-word-fall-through read mode (FWFT parameter).
// Optional build macro SYNC_FIFO_ERR_EN enables the sticky overflow/underflow
// flags; without it both flags are tied low and err_clr is ignored.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = MODE_STD
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        rd_en,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        rd_valid,
   output logic                        full,
   output logic                        empty,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [cnt_width(DEPTH)-1:0] count,
   output logic                        overflow,
   output logic                        underflow,
   input  logic                        err_clr
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [WIDTH-1:0] mem_rdata;
   logic             rd_acc;
   logic             wr_acc;

   // A read is only accepted with data present; a write is accepted when
   // there is room or when a same-cycle read frees a slot.
   assign rd_acc = rd_en & ~empty;
   assign wr_acc = wr_en & (~full | rd_acc);

   // Flags come straight from the count register, never from pointer compare
   assign full         = (count == CNT_FULL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_AF);
   assign almost_empty = (count <= CNT_AE);

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr),
      .wdata (wr_data),
      .raddr (rptr),
      .rdata (mem_rdata)
   );

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count as is
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_acc) begin
            wptr <= PW'(ptr_inc(int'(wptr), DEPTH));
         end
         if (rd_acc) begin
            rptr <= PW'(ptr_inc(int'(rptr), DEPTH));
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   generate
      if (FWFT == MODE_FWFT) begin : g_fwft
         // Head word is presented before the pop; masked to zero while empty
         // so the output never exposes stale or uninitialised storage.
         assign rd_data  = empty ? '0 : mem_rdata;
         assign rd_valid = ~empty;
      end else begin : g_std
         logic [WIDTH-1:0] rd_data_p1;
         logic             vld_p1;

         // ---- stage p1: registered head word, valid pulses for one cycle per pop
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data_p1 <= '0;
               vld_p1     <= 1'b0;
            end else begin
               vld_p1 <= rd_acc;
               if (rd_acc) begin
                  rd_data_p1 <= mem_rdata;
               end
            end
         end

         assign rd_data  = rd_data_p1;
         assign rd_valid = vld_p1;
      end
   endgenerate

`ifdef SYNC_FIFO_ERR_EN
   logic overflow_q;
   logic underflow_q;

   // Sticky error capture; a clear in the same cycle as a new error wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (err_clr) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_en & ~wr_acc) begin
            overflow_q <= 1'b1;
         end
         if (rd_en & empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed bench for sync_fifo_param. Three instances share
// one stimulus stream: depth 8 standard mode, depth 8 FWFT, depth 5 standard.
// Each is checked every cycle against a queue-style reference model; directed
// literal checks pin the model on the key scenarios.
`timescale 1ns/1ps
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk     = 1'b0;
   logic        rst     = 1'b1;
   logic        wr_en   = 1'b0;
   logic        rd_en   = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] wr_data = '0;

   logic [15:0] rdd [3];
   logic        rv  [3];
   logic        fu  [3];
   logic        em  [3];
   logic        af  [3];
   logic        ae  [3];
   logic        ov  [3];
   logic        un  [3];
   logic [3:0]  cnt [3];
   logic [3:0]  c8a;
   logic [3:0]  c8b;
   logic [2:0]  c5;

   int checks   = 0;
   int failures = 0;

   // reference model: element 0 of mq is always the oldest word
   logic [15:0] mq  [3][8];
   int          mc  [3];
   logic [15:0] mrd [3];
   bit          mvld[3];
   bit          mov [3];
   bit          mun [3];

   always #5 clk = ~clk;

   sync_fifo_param #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rdd[0]), .rd_valid(rv[0]), .full(fu[0]), .empty(em[0]),
      .almost_full(af[0]), .almost_empty(ae[0]), .count(c8a),
      .overflow(ov[0]), .underflow(un[0]), .err_clr(err_clr));

   sync_fifo_param #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rdd[1]), .rd_valid(rv[1]), .full(fu[1]), .empty(em[1]),
      .almost_full(af[1]), .almost_empty(ae[1]), .count(c8b),
      .overflow(ov[1]), .underflow(un[1]), .err_clr(err_clr));

   sync_fifo_param #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(0)) u_d5 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rdd[2]), .rd_valid(rv[2]), .full(fu[2]), .empty(em[2]),
      .almost_full(af[2]), .almost_empty(ae[2]), .count(c5),
      .overflow(ov[2]), .underflow(un[2]), .err_clr(err_clr));

   assign cnt[0] = c8a;
   assign cnt[1] = c8b;
   assign cnt[2] = {1'b0, c5};

   function automatic int dep(input int i);
      return (i == 2) ? 5 : 8;
   endfunction

   function automatic bit is_fwft(input int i);
      return (i == 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mc[i]   = 0;
         mrd[i]  = '0;
         mvld[i] = 1'b0;
         mov[i]  = 1'b0;
         mun[i]  = 1'b0;
      end
   endtask

   // one rising edge of the reference model, using the inputs seen at that edge
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         bit emp;
         bit ful;
         bit racc;
         bit wacc;
         emp  = (mc[i] == 0);
         ful  = (mc[i] == dep(i));
         racc = rd_en && !emp;
         wacc = wr_en && (!ful || racc);
         if (ERR_EN) begin
            if (err_clr) begin
               mov[i] = 1'b0;
               mun[i] = 1'b0;
            end else begin
               if (wr_en && !wacc) mov[i] = 1'b1;
               if (rd_en && emp)   mun[i] = 1'b1;
            end
         end
         mvld[i] = 1'b0;
         if (racc) begin
            if (!is_fwft(i)) begin
               mrd[i]  = mq[i][0];
               mvld[i] = 1'b1;
            end
            for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
            mc[i]--;
         end
         if (wacc) begin
            mq[i][mc[i]] = wr_data;
            mc[i]++;
         end
      end
   endtask

   // per-cycle comparison of every instance against the model
   task automatic cmp();
      for (int i = 0; i < 3; i++) begin
         string tag;
         tag = $sformatf("u%0d", i);
         chk({tag, ".count"}, 32'(cnt[i]), 32'(mc[i]));
         chk({tag, ".full"},  32'(fu[i]),  32'(mc[i] == dep(i)));
         chk({tag, ".empty"}, 32'(em[i]),  32'(mc[i] == 0));
         chk({tag, ".afull"}, 32'(af[i]),  32'(mc[i] >= dep(i) - 2));
         chk({tag, ".aempty"},32'(ae[i]),  32'(mc[i] <= 2));
         chk({tag, ".ovf"},   32'(ov[i]),  32'(mov[i]));
         chk({tag, ".unf"},   32'(un[i]),  32'(mun[i]));
         if (is_fwft(i)) begin
            chk({tag, ".rvalid"}, 32'(rv[i]), 32'(mc[i] != 0));
            if (mc[i] != 0) chk({tag, ".rdata"}, 32'(rdd[i]), 32'(mq[i][0]));
         end else begin
            chk({tag, ".rvalid"}, 32'(rv[i]),  32'(mvld[i]));
            chk({tag, ".rdata"},  32'(rdd[i]), 32'(mrd[i]));
         end
      end
   endtask

   task automatic cyc(input bit we, input logic [15:0] wd, input bit re, input bit ec);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      err_clr = ec;
      @(posedge clk);
      model_step();
      @(negedge clk);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      cmp();
   endtask

   initial begin
      model_reset();
      #1;
      chk("rst.count",  32'(c8a),    32'd0);
      chk("rst.empty",  32'(em[0]),  32'd1);
      chk("rst.full",   32'(fu[0]),  32'd0);
      chk("rst.aempty", 32'(ae[0]),  32'd1);
      chk("rst.afull",  32'(af[0]),  32'd0);
      chk("rst.rdata",  32'(rdd[0]), 32'd0);
      chk("rst.rvalid", 32'(rv[0]),  32'd0);
      chk("rst.ovf",    32'(ov[0]),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      cmp();

      // fill depth-8 to full; almost_full from the 6th write
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 16'h1000 + 16'(k), 1'b0, 1'b0);
         if (k == 4) chk("fill.afull5", 32'(af[0]), 32'd0);
         if (k == 5) chk("fill.afull6", 32'(af[0]), 32'd1);
      end
      chk("fill.count", 32'(c8a),   32'd8);
      chk("fill.full",  32'(fu[0]), 32'd1);

      // write into a full FIFO is rejected
      cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
      chk("ovf.flag",  32'(ov[0]), 32'(ERR_EN));
      chk("ovf.count", 32'(c8a),   32'd8);

      // full with simultaneous write and read
      cyc(1'b1, 16'h2222, 1'b1, 1'b0);
      chk("fullrw.rdata", 32'(rdd[0]), 32'h1000);
      chk("fullrw.count", 32'(c8a),    32'd8);

      // drain: 0x1001..0x1007 then 0x2222
      for (int k = 0; k < 8; k++) begin
         cyc(1'b0, 16'h0, 1'b1, 1'b0);
         chk("drain.rdata", 32'(rdd[0]), (k < 7) ? 32'h1001 + 32'(k) : 32'h2222);
      end
      chk("drain.empty", 32'(em[0]), 32'd1);

      // read of an empty FIFO, then clear
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("unf.flag",   32'(un[0]),  32'(ERR_EN));
      chk("unf.rdata",  32'(rdd[0]), 32'h2222);
      chk("unf.rvalid", 32'(rv[0]),  32'd0);
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      chk("clr.unf", 32'(un[0]), 32'd0);
      chk("clr.ovf", 32'(ov[0]), 32'd0);

      // back-to-back write/read pairs; depth-5 pointers wrap twice
      for (int k = 0; k < 12; k++) begin
         cyc(1'b1, 16'(k), 1'b1, 1'b0);
         chk("wrap.count", 32'(c5), 32'd1);
         if (k >= 1) begin
            chk("wrap.rvalid", 32'(rv[2]),  32'd1);
            chk("wrap.rdata",  32'(rdd[2]), 32'(k - 1));
         end
      end
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("wrap.last", 32'(rdd[2]), 32'h000B);
      chk("wrap.empty", 32'(em[2]), 32'd1);

      // FWFT: data visible before any pop
      cyc(1'b1, 16'hABCD, 1'b0, 1'b0);
      chk("fwft.empty",  32'(em[1]),  32'd0);
      chk("fwft.rvalid", 32'(rv[1]),  32'd1);
      chk("fwft.rdata",  32'(rdd[1]), 32'hABCD);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("fwft.pop.empty",  32'(em[1]), 32'd1);
      chk("fwft.pop.rvalid", 32'(rv[1]), 32'd0);

      // three writes, one read, then asynchronous reset mid-cycle
      cyc(1'b1, 16'h0011, 1'b0, 1'b0);
      cyc(1'b1, 16'h0022, 1'b0, 1'b0);
      cyc(1'b1, 16'h0033, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("pre.rdata", 32'(rdd[0]), 32'h0011);
      chk("pre.count", 32'(c8a),    32'd2);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst.count",  32'(c8a),    32'd0);
      chk("arst.empty",  32'(em[0]),  32'd1);
      chk("arst.aempty", 32'(ae[0]),  32'd1);
      chk("arst.rdata",  32'(rdd[0]), 32'd0);
      chk("arst.rvalid", 32'(rv[0]),  32'd0);
      chk("arst.fwft",   32'(rv[1]),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      cmp();

      // normal operation resumes after reset
      cyc(1'b1, 16'h0055, 1'b0, 1'b0);
      cyc(1'b0, 16'h0, 1'b1, 1'b0);
      chk("post.rdata", 32'(rdd[0]), 32'h0055);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
